bus_slave_port: RTL and testbench

Slave-side endpoint of the serial system bus. It produces the per-slave `ready` that the bus ready multiplexer forwards to the master. It accepts a master request, deserialises the address and write data, and drives a local synchronous memory. For reads it serialises the memory word back to the master. One instance sits in front of each slave (s1..s3).

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_shift_reg.sv | 37 +++
 rtl/bus_slave_port.sv | 126 ++++++++++++
 tb/tb_bus_slave_port.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared serial system bus types and defaults
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WRITE,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_RDATA
    } slave_state_t;

    localparam logic BUS_MODE_READ  = 1'b0;
    localparam logic BUS_MODE_WRITE = 1'b1;

    localparam int BUS_ADDR_W = 12;
    localparam int BUS_DATA_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - LSB-first serial-in / parallel-load / serial-out shift register
module bus_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // New bits enter at the MSB so the first bit received ends up at bit 0.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {sin_i, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/bus_slave_port.sv
// rtl/bus_slave_port.sv - serial bus slave endpoint driving a local synchronous memory
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_sel,
    input  logic              m_valid,
    input  logic              m_mode,
    input  logic              m_wdata,
    output logic              s_ready,
    output logic              s_rdata,
    output logic              s_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int MAX_W = max_int(ADDR_W, DATA_W);
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    slave_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               s_ready_q, s_rvalid_q, s_rdata_q, mem_we_q;
    logic               s_rdata_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = addr_q[0];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (m_valid && s_sel) begin
                    state_d = ST_ADDR;
                    mode_d  = m_mode;
                end
            end
            ST_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    // Last address bit is still on the wire; fold it in directly.
                    mem_addr_d = {m_wdata, addr_q[ADDR_W-1:1]};
                    state_d    = (mode_q == BUS_MODE_WRITE) ? ST_WDATA : ST_READ_REQ;
                end
            end
            ST_WDATA:     if (cnt_q == DATA_LAST) state_d = ST_WRITE;
            ST_WRITE:     state_d = ST_IDLE;
            ST_READ_REQ:  state_d = ST_READ_WAIT;
            ST_READ_WAIT: state_d = ST_RDATA;
            ST_RDATA:     if (cnt_q == DATA_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        cnt_d = (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + CNT_ONE;

        // s_rdata is registered, so it looks one bit ahead of the shift register.
        s_rdata_d = 1'b0;
        if (state_d == ST_RDATA) begin
            s_rdata_d = (state_q == ST_READ_WAIT) ? mem_rdata[0] : data_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_q     <= BUS_MODE_READ;
            mem_addr_q <= '0;
            s_ready_q  <= 1'b1;
            s_rvalid_q <= 1'b0;
            s_rdata_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            mem_addr_q <= mem_addr_d;
            s_ready_q  <= (state_d == ST_IDLE);
            s_rvalid_q <= (state_d == ST_RDATA);
            s_rdata_q  <= s_rdata_d;
            mem_we_q   <= (state_d == ST_WRITE);
        end
    end

    bus_shift_reg #(.W(ADDR_W)) u_addr_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (state_q == ST_ADDR),
        .sin_i       (m_wdata),
        .q_o         (addr_q)
    );

    // Shared by the write-data and read-data paths; its contents are mem_wdata.
    bus_shift_reg #(.W(DATA_W)) u_data_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (state_q == ST_READ_WAIT),
        .load_data_i (mem_rdata),
        .shift_i     (state_q == ST_WDATA || state_q == ST_RDATA),
        .sin_i       (m_wdata && (state_q == ST_WDATA)),
        .q_o         (data_q)
    );

    assign s_ready   = s_ready_q;
    assign s_rvalid  = s_rvalid_q;
    assign s_rdata   = s_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// tb/tb_bus_slave_port.sv - directed self-checking bench for bus_slave_port
module tb_bus_slave_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_sel, m_valid, m_mode, m_wdata;
    logic        s_ready, s_rdata, s_rvalid, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          errors = 0;
    int          we_count = 0;
    int          wc;

    always #5 clk = ~clk;

    bus_slave_port #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_sel     (s_sel),
        .m_valid   (m_valid),
        .m_mode    (m_mode),
        .m_wdata   (m_wdata),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_count++;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [7:0] data,
                            input bit busy, input bit dropsel);
        check("w_ready_idle", s_ready, 1);
        s_sel = 1; m_valid = 1; m_mode = 1;
        step();
        m_valid = 0; m_mode = 0;
        check("w_ready_busy", s_ready, 0);
        for (int i = 0; i < 12; i++) begin
            m_wdata = addr[i];
            m_valid = busy && (i == 4);
            if (dropsel && i == 2) s_sel = 0;
            step();
        end
        m_valid = 0;
        for (int i = 0; i < 8; i++) begin
            m_wdata = data[i];
            m_valid = busy && (i == 3);
            check("w_no_early_we", mem_we, 0);
            step();
        end
        m_valid = 0; m_wdata = 0;
        check("w_we", mem_we, 1);
        check("w_addr", mem_addr, addr);
        check("w_wdata", mem_wdata, data);
        step();
        check("w_we_off", mem_we, 0);
        check("w_ready_back", s_ready, 1);
        s_sel = 1;
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [7:0] exp, input bit busy);
        check("r_ready_idle", s_ready, 1);
        s_sel = 1; m_valid = 1; m_mode = 0;
        step();
        m_valid = 0;
        for (int i = 0; i < 12; i++) begin
            m_wdata = addr[i];
            m_valid = busy && (i == 5);
            m_mode  = busy && (i == 5);
            step();
        end
        m_valid = 0; m_mode = 0; m_wdata = 0;
        check("r_req_rvalid", s_rvalid, 0);
        check("r_req_addr", mem_addr, addr);
        step();
        check("r_wait_rvalid", s_rvalid, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            check("r_rvalid", s_rvalid, 1);
            check("r_bit", s_rdata, exp[i]);
            check("r_ready_low", s_ready, 0);
            m_valid = busy && (i == 2);
            step();
        end
        m_valid = 0;
        check("r_ready_back", s_ready, 1);
        check("r_rvalid_off", s_rvalid, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst_n = 0; s_sel = 0; m_valid = 0; m_mode = 0; m_wdata = 0;
        step();
        step();
        check("rst_ready", s_ready, 1);
        check("rst_rdata", s_rdata, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1;
        step();

        m_valid = 1; s_sel = 0; m_mode = 1;
        step();
        m_valid = 0;
        check("nosel_ready", s_ready, 1);
        step();
        check("nosel_ready2", s_ready, 1);

        do_write(12'h123, 8'hA5, 0, 0);
        do_read(12'h123, 8'hA5, 0);

        do_write(12'h2B4, 8'h5A, 1, 0);
        do_read(12'h2B4, 8'h5A, 1);

        do_write(12'h7E1, 8'hC3, 0, 1);
        check("desel_mem", mem[12'h7E1], 8'hC3);

        do_write(12'h0FF, 8'h3C, 0, 0);
        do_read(12'h0FF, 8'h3C, 0);

        s_sel = 1; m_valid = 1; m_mode = 1;
        step();
        m_valid = 0; m_wdata = 1;
        for (int i = 0; i < 15; i++) step();
        wc = we_count;
        rst_n = 0;
        #1;
        check("mid_rst_ready", s_ready, 1);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_rvalid", s_rvalid, 0);
        step();
        step();
        rst_n = 1; s_sel = 0;
        for (int i = 0; i < 12; i++) step();
        check("mid_rst_no_we", we_count, wc);
        check("mid_rst_idle", s_ready, 1);
        check("mid_rst_mem", mem[12'hFFF], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
